// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic.
// Both the write-side full logic and the read-side empty logic use this package.
package fifo_pkg;

    localparam int GW = 32;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for Gray-coded pointers crossing clock domains.
// Only one bit changes per pointer step, so a metastable sample resolves to old or new.
module sync2 #(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] d,
    output logic [SW-1:0] q
);

    logic [SW-1:0] q1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer, RAM write address/enable and full/almost-full/fill/overflow
// flags for the dual-clock FIFO, clocked by w_clk.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6,
    localparam int A          = $clog2(DEPTH),
    localparam int PW         = ptr_w(DEPTH)
) (
    input  logic         w_clk,
    input  logic         rst_n,
    input  logic         wr_rq,
    input  logic [A:0]   rptr,
    output logic [A-1:0] waddr,
    output logic [A:0]   wptr,
    output logic         wr_en,
    output logic         full,
    output logic         almost_full,
    output logic [A:0]   wcount,
    output logic         overflow
);

    if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
        AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_param_check
        $error("wptr_full: illegal WIDTH/DEPTH/AFULL_LEVEL");
    end

    localparam logic [PW-1:0] AFULL_TH = PW'(AFULL_LEVEL);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] fill_next;
    logic          full_next;

    sync2 #(.SW(PW)) u_sync_rptr (
        .clk   (w_clk),
        .rst_n (rst_n),
        .d     (rptr),
        .q     (wq2_rptr)
    );

    assign wr_en = wr_rq & ~full;
    assign waddr = wbin[A-1:0];

    // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
    always_comb begin
        wbin_next  = wbin + PW'(wr_en);
        wgray_next = PW'(bin2gray(GW'(wbin_next)));
        rbin_sync  = PW'(gray2bin(GW'(wq2_rptr)));
        fill_next  = wbin_next - rbin_sync;
        full_next  = (wgray_next == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]});
    end

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wcount      <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            full        <= full_next;
            almost_full <= (fill_next >= AFULL_TH);
            wcount      <= fill_next;
            if (wr_rq && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// Directed self-checking bench for wptr_full with DEPTH=8, AFULL_LEVEL=6.
module tb_wptr_full;

    localparam int DEPTH       = 8;
    localparam int AFULL_LEVEL = 6;
    localparam int A           = 3;

    logic         w_clk = 1'b0;
    logic         rst_n;
    logic         wr_rq;
    logic [A:0]   rptr;
    logic [A-1:0] waddr;
    logic [A:0]   wptr;
    logic         wr_en;
    logic         full;
    logic         almost_full;
    logic [A:0]   wcount;
    logic         overflow;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    wptr_full #(
        .WIDTH       (4),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL_LEVEL)
    ) dut (
        .w_clk       (w_clk),
        .rst_n       (rst_n),
        .wr_rq       (wr_rq),
        .rptr        (rptr),
        .waddr       (waddr),
        .wptr        (wptr),
        .wr_en       (wr_en),
        .full        (full),
        .almost_full (almost_full),
        .wcount      (wcount),
        .overflow    (overflow)
    );

    always #5 w_clk = ~w_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string pfx, input int e_waddr, input int e_wptr,
                              input int e_full, input int e_afull, input int e_wcount,
                              input int e_ovf, input int e_wr_en);
        checkOutput({pfx, ".waddr"},       32'(waddr),       32'(e_waddr));
        checkOutput({pfx, ".wptr"},        32'(wptr),        32'(e_wptr));
        checkOutput({pfx, ".full"},        32'(full),        32'(e_full));
        checkOutput({pfx, ".almost_full"}, 32'(almost_full), 32'(e_afull));
        checkOutput({pfx, ".wcount"},      32'(wcount),      32'(e_wcount));
        checkOutput({pfx, ".overflow"},    32'(overflow),    32'(e_ovf));
        checkOutput({pfx, ".wr_en"},       32'(wr_en),       32'(e_wr_en));
    endtask

    task automatic applyStimulus();
        @(posedge w_clk);
        #1;
    endtask

    initial begin
        int n;

        // Reset with no clock edge yet
        rst_n = 1'b0;
        wr_rq = 1'b0;
        rptr  = '0;
        #3;
        checkState("rst", 0, 0, 0, 0, 0, 0, 0);
        wr_rq = 1'b1;
        #1;
        checkOutput("rst.wr_en_follows_rq", 32'(wr_en), 32'd1);
        wr_rq = 1'b0;
        @(negedge w_clk);
        @(negedge w_clk);
        rst_n = 1'b1;
        applyStimulus();
        applyStimulus();
        checkState("idle", 0, 0, 0, 0, 0, 0, 0);

        // Fill past full with the read pointer parked at 0
        wr_rq = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus();
            n = (k < 8) ? k : 8;
            checkState($sformatf("fill%0d", k), n % 8, int'(gray_tab[n]), int'(n == 8),
                       int'(n >= 6), n, int'(k >= 9), int'(n < 8));
        end

        // One read observed: full drops only on the third edge
        wr_rq = 1'b0;
        rptr  = 4'b0001;
        applyStimulus();
        checkState("rel1", 0, 'hC, 1, 1, 8, 1, 0);
        applyStimulus();
        checkState("rel2", 0, 'hC, 1, 1, 8, 1, 0);
        applyStimulus();
        checkState("rel3", 0, 'hC, 0, 1, 7, 1, 0);
        wr_rq = 1'b1;
        #1;
        checkOutput("rel.wr_en", 32'(wr_en), 32'd1);
        applyStimulus();
        checkState("refull", 1, 'hD, 1, 1, 8, 1, 0);

        // Asynchronous reset while full and overflowed
        #2;
        rst_n = 1'b0;
        #1;
        checkState("midrst", 0, 0, 0, 0, 0, 0, 1);
        wr_rq = 1'b0;
        rptr  = '0;
        @(negedge w_clk);
        rst_n = 1'b1;
        wr_rq = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus();
            checkState($sformatf("post%0d", k), k % 8, int'(gray_tab[k]), int'(k == 8),
                       int'(k >= 6), k, 0, int'(k < 8));
        end

        // Wrap: reader trails two entries behind, seen fill saturates at 5
        wr_rq = 1'b0;
        rst_n = 1'b0;
        rptr  = '0;
        @(negedge w_clk);
        rst_n = 1'b1;
        wr_rq = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            applyStimulus();
            n = (e < 5) ? e : 5;
            checkState($sformatf("wrap%0d", e), e % 8, int'(gray_tab[e % 16]), 0, 0, n, 0, 1);
            rptr = (e >= 2) ? gray_tab[(e - 2) % 16] : 4'h0;
        end
        wr_rq = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
